decode_stage_hz: RTL and testbench
==================================

Name: decode_stage_hz

Overview:
Parametrised decode stage: the next generation of the single-width decode stage. It contains the IF/ID pipeline register with stall and flush, a register file with write-through bypass, and an immediate generator. It resolves branches and jumps in decode, using MEM-stage forwarding selected internally. A hazard unit with a counter inserts load-use and branch-dependency bubbles. It sits between fetch and the ID/EX register.

Parameters:
XLEN, 16, register/data width (>=16); immediates sign-extend to XLEN
NREGS, 8, register count; register 0 hardwired to zero; address field 3 bits, so NREGS<=8
LOAD_LAT, 1, bubbles inserted for an ALU consumer of a load result in EX (1..3)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pc_in  in  16  fetch PC
ir_in  in  16  fetched instruction
valid_in  in  1  fetch output valid
wb_we  in  1  writeback enable
wb_addr  in  3  writeback register
wb_data  in  XLEN  writeback data
ex_we, ex_is_load  in  1 each  ID/EX instruction writes a register / is a load
ex_rd  in  3  ID/EX destination
mem_we  in  1  EX/MEM instruction writes a register
mem_rd  in  3  EX/MEM destination
mem_data  in  XLEN  EX/MEM result (forward source)
stall  out  1  hold PC and do not advance fetch
redirect  out  1  taken branch/jump this cycle
redirect_pc  out  16  target PC
id_valid  out  1  decode outputs are a real instruction (0 = bubble)
id_pc  out  16  IF/ID PC
opcode  out  3  ir[2:0]
func  out  4  ir[15:12]
rs1, rs2, rd  out  3 each  ir[8:6], ir[11:9], ir[5:3]
arg1, arg2  out  XLEN  register reads of rs1 and rs2 (bypassed)
imm  out  XLEN  generated immediate

Behaviour:
- Opcodes:
  - 000 R-type, 001 I-type, 010 load, 011 store.
  - 100 beq, 101 bne, 110 blt (signed).
  - 111 jr: target = R[rd] + imm.
- Immediates:
  - I-type/load/store and jr: sext(ir[15:9]).
  - Branch: sext({ir[15:12],ir[5:3]}) << 1.
  - R-type: 0.
- IF/ID register, in priority order:
  - reset low (async): pc=0, ir=0, valid=0.
  - Else on the edge with stall=1: hold.
  - Else redirect=1: load bubble (valid=0, ir=0).
  - Else capture pc_in, ir_in, valid_in.
- Register file:
  - Synchronous write when wb_we and wb_addr != 0.
  - Reads combinational; when wb_we and wb_addr matches a read address (!= 0), the read returns wb_data in the same cycle.
  - Reset clears all registers.
- Compare/jump operand forwarding, per operand:
  - If mem_we and mem_rd == src and src != 0, use mem_data.
  - Else use the bypassed register read.
  - arg1/arg2 outputs are NOT forwarded (EX has its own forwarding).
- Hazard detection applies only when IF/ID valid. Let src be the registers read (rs1, rs2, or rd for jr), excluding 0.
  - H_LU: ex_is_load and ex_rd matches a src of a non-branch/non-jump instruction: need LOAD_LAT bubbles.
  - H_BR: a branch/jr src matches ex_rd with ex_we: need 1 bubble if not a load, LOAD_LAT+1 if a load.
- Stall counter cnt (2 bits, reset 0):
  - When cnt==0 and a hazard is detected: stall=1 this cycle and cnt loads (need-1).
  - While cnt!=0: stall=1 and cnt decrements.
  - Hazard is re-evaluated when cnt==0.
  - stall is combinational: (cnt!=0) | hazard_now.
- id_valid = IF/ID valid & !stall. When stalled, the ID/EX stage receives a bubble.
- Branch resolution (combinational; only when id_valid=1):
  - Branch taken → redirect=1, redirect_pc = id_pc + imm (16-bit wrap).
  - jr → redirect=1, redirect_pc = fwd(R[rd]) + imm, truncated to 16 bits.
- Simultaneous events:
  - stall and redirect cannot both be 1; stall suppresses redirect.
  - wb write to a register being forwarded from MEM: the MEM value wins.
- Reset mid-stall clears cnt; stall=0 after release.
- Reset values: stall=0, redirect=0, redirect_pc=0, id_valid=0, id_pc=0, opcode/func/rs/rd=0, imm=0. arg1/arg2 = 0 because the registers are cleared.

Test Plan:
- Reset asserted mid-stream (cnt=1) → all outputs 0 immediately; after release, first valid_in instruction appears with id_valid=1 one edge later.
- wb_we=1, wb_addr=3, wb_data=0x00AB, decoding R-type rs1=3 in the same cycle → arg1=0x00AB; wb_addr=0 write → arg1 of r0 stays 0.
- Load in EX (ex_rd=2, ex_is_load=1), decode R-type rs2=2, LOAD_LAT=2 → stall=1 for exactly 2 cycles, id_valid=0 both, IF/ID held, instruction issues on 3rd cycle.
- beq r1,r2 with r1=5 and mem_we=1, mem_rd=2, mem_data=5, id_pc=0x0010, imm=+6 → redirect=1, redirect_pc=0x0016; next edge IF/ID holds bubble.
- bne dependent on ALU op in EX (ex_we=1, ex_rd=1, not a load) → 1 stall cycle with redirect=0; resolves next cycle once MEM forwarding is active.
- jr with R[rd]=0xFFFE, imm=+4 → redirect_pc=0x0002 (wrap); blt with -1 vs 1 → taken.

Source files
------------

// File: rtl/decode_stage_hz_if.sv
// Fetch/writeback/forwarding inputs and decode outputs of the decode stage.
interface decode_stage_hz_if #(
    parameter int unsigned XLEN = 16
);
    logic [15:0]     pc_in;
    logic [15:0]     ir_in;
    logic            valid_in;
    logic            wb_we;
    logic [2:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            ex_we;
    logic            ex_is_load;
    logic [2:0]      ex_rd;
    logic            mem_we;
    logic [2:0]      mem_rd;
    logic [XLEN-1:0] mem_data;

    logic            stall;
    logic            redirect;
    logic [15:0]     redirect_pc;
    logic            id_valid;
    logic [15:0]     id_pc;
    logic [2:0]      opcode;
    logic [3:0]      func;
    logic [2:0]      rs1;
    logic [2:0]      rs2;
    logic [2:0]      rd;
    logic [XLEN-1:0] arg1;
    logic [XLEN-1:0] arg2;
    logic [XLEN-1:0] imm;

    modport slave (
        input  pc_in, ir_in, valid_in, wb_we, wb_addr, wb_data,
               ex_we, ex_is_load, ex_rd, mem_we, mem_rd, mem_data,
        output stall, redirect, redirect_pc, id_valid, id_pc, opcode, func,
               rs1, rs2, rd, arg1, arg2, imm
    );

    modport master (
        output pc_in, ir_in, valid_in, wb_we, wb_addr, wb_data,
               ex_we, ex_is_load, ex_rd, mem_we, mem_rd, mem_data,
        input  stall, redirect, redirect_pc, id_valid, id_pc, opcode, func,
               rs1, rs2, rd, arg1, arg2, imm
    );
endinterface

// File: rtl/decode_stage_hz.sv
// Decode stage: IF/ID register, bypassed register file, immediate generator,
// branch/jump resolution with MEM forwarding, and load/branch hazard stalls.
module decode_stage_hz #(
    parameter int unsigned XLEN     = 16,
    parameter int unsigned NREGS    = 8,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    decode_stage_hz_if.slave bus
);
    localparam logic [2:0] OP_ITYPE = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_BNE   = 3'b101;
    localparam logic [2:0] OP_BLT   = 3'b110;
    localparam logic [2:0] OP_JR    = 3'b111;

    logic [15:0]     r_pc;
    logic [15:0]     r_ir;
    logic            r_valid;
    logic [1:0]      r_cnt;
    logic [XLEN-1:0] r_regs [1:NREGS-1];

    logic [2:0]      w_op, w_rs1, w_rs2, w_rd;
    logic [3:0]      w_func;
    logic            w_is_br, w_is_jr;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rf1, w_rf2, w_rfd;
    logic [XLEN-1:0] w_rd1, w_rd2, w_rdd;
    logic [XLEN-1:0] w_f1, w_f2, w_fd;
    logic            w_src_hit, w_h_lu, w_h_br, w_hazard, w_stall;
    logic [2:0]      w_need;
    logic [1:0]      w_cnt_nxt;
    logic            w_taken, w_id_valid, w_redirect;
    logic [15:0]     w_target;

    assign w_op    = r_ir[2:0];
    assign w_rd    = r_ir[5:3];
    assign w_rs1   = r_ir[8:6];
    assign w_rs2   = r_ir[11:9];
    assign w_func  = r_ir[15:12];
    assign w_is_br = (w_op == OP_BEQ) || (w_op == OP_BNE) || (w_op == OP_BLT);
    assign w_is_jr = (w_op == OP_JR);

    // Immediate generator; branch offsets are halfword-scaled
    always_comb begin
        w_imm = '0;
        case (w_op)
            OP_ITYPE, OP_LOAD, OP_STORE, OP_JR:
                w_imm = {{(XLEN-7){r_ir[15]}}, r_ir[15:9]};
            OP_BEQ, OP_BNE, OP_BLT:
                w_imm = {{(XLEN-8){r_ir[15]}}, r_ir[15:12], r_ir[5:3], 1'b0};
            default: w_imm = '0;
        endcase
    end

    // Register array reads; addresses beyond NREGS and r0 read as zero
    always_comb begin
        w_rf1 = '0;
        w_rf2 = '0;
        w_rfd = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            if (w_rs1 == 3'(i)) w_rf1 = r_regs[i];
            if (w_rs2 == 3'(i)) w_rf2 = r_regs[i];
            if (w_rd  == 3'(i)) w_rfd = r_regs[i];
        end
    end

    // Write-through bypass from writeback
    assign w_rd1 = (bus.wb_we && bus.wb_addr == w_rs1 && w_rs1 != 3'd0) ? bus.wb_data : w_rf1;
    assign w_rd2 = (bus.wb_we && bus.wb_addr == w_rs2 && w_rs2 != 3'd0) ? bus.wb_data : w_rf2;
    assign w_rdd = (bus.wb_we && bus.wb_addr == w_rd  && w_rd  != 3'd0) ? bus.wb_data : w_rfd;

    // MEM forwarding for compare/jump operands only; it overrides writeback
    assign w_f1 = (bus.mem_we && bus.mem_rd == w_rs1 && w_rs1 != 3'd0) ? bus.mem_data : w_rd1;
    assign w_f2 = (bus.mem_we && bus.mem_rd == w_rs2 && w_rs2 != 3'd0) ? bus.mem_data : w_rd2;
    assign w_fd = (bus.mem_we && bus.mem_rd == w_rd  && w_rd  != 3'd0) ? bus.mem_data : w_rdd;

    assign w_src_hit = w_is_jr ? (w_rd != 3'd0 && w_rd == bus.ex_rd)
                               : ((w_rs1 != 3'd0 && w_rs1 == bus.ex_rd) ||
                                  (w_rs2 != 3'd0 && w_rs2 == bus.ex_rd));
    assign w_h_lu = r_valid && !(w_is_br || w_is_jr) && bus.ex_is_load && w_src_hit;
    assign w_h_br = r_valid && (w_is_br || w_is_jr) && bus.ex_we && w_src_hit;
    assign w_need = w_h_br ? (bus.ex_is_load ? 3'(LOAD_LAT + 1) : 3'd1) : 3'(LOAD_LAT);

    // A new hazard is only considered once the previous bubble run is done
    assign w_hazard   = (r_cnt == 2'd0) && (w_h_lu || w_h_br);
    assign w_stall    = (r_cnt != 2'd0) || w_hazard;
    assign w_id_valid = r_valid && !w_stall;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_cnt != 2'd0)
            w_cnt_nxt = r_cnt - 2'd1;
        else if (w_hazard)
            w_cnt_nxt = 2'(w_need - 3'd1);
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_op)
            OP_BEQ:  w_taken = (w_f1 == w_f2);
            OP_BNE:  w_taken = (w_f1 != w_f2);
            OP_BLT:  w_taken = ($signed(w_f1) < $signed(w_f2));
            default: w_taken = 1'b0;
        endcase
    end

    assign w_redirect = w_id_valid && (w_taken || w_is_jr);
    assign w_target   = w_is_jr ? 16'(w_fd + w_imm) : (r_pc + 16'(w_imm));

    // IF/ID register; a squashed slot keeps the fetched PC but no instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_ir    <= '0;
            r_valid <= 1'b0;
        end else if (!w_stall) begin
            r_pc <= bus.pc_in;
            if (w_redirect) begin
                r_ir    <= '0;
                r_valid <= 1'b0;
            end else begin
                r_ir    <= bus.ir_in;
                r_valid <= bus.valid_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= w_cnt_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < NREGS; i++)
                if (bus.wb_we && bus.wb_addr == 3'(i)) r_regs[i] <= bus.wb_data;
        end
    end

    assign bus.stall       = w_stall;
    assign bus.redirect    = w_redirect;
    assign bus.redirect_pc = w_redirect ? w_target : 16'd0;
    assign bus.id_valid    = w_id_valid;
    assign bus.id_pc       = r_pc;
    assign bus.opcode      = w_op;
    assign bus.func        = w_func;
    assign bus.rs1         = w_rs1;
    assign bus.rs2         = w_rs2;
    assign bus.rd          = w_rd;
    assign bus.arg1        = w_rd1;
    assign bus.arg2        = w_rd2;
    assign bus.imm         = w_imm;
endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed scenarios plus a randomized run against a behavioural decode model.
module tb_decode_stage_hz;
    localparam int unsigned XLEN = 16;
    localparam int unsigned LL   = 2;

    localparam logic [2:0] OP_R   = 3'b000;
    localparam logic [2:0] OP_BEQ = 3'b100;
    localparam logic [2:0] OP_BNE = 3'b101;
    localparam logic [2:0] OP_BLT = 3'b110;
    localparam logic [2:0] OP_JR  = 3'b111;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_stage_hz_if #(.XLEN(XLEN)) bus();

    decode_stage_hz #(.XLEN(XLEN), .NREGS(8), .LOAD_LAT(LL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [15:0] enc(input logic [3:0] f, input logic [2:0] r2,
                                        input logic [2:0] r1, input logic [2:0] d,
                                        input logic [2:0] op);
        return {f, r2, r1, d, op};
    endfunction

    function automatic logic [98:0] all_out();
        return {bus.stall, bus.redirect, bus.redirect_pc, bus.id_valid, bus.id_pc,
                bus.opcode, bus.func, bus.rs1, bus.rs2, bus.rd, bus.arg1, bus.arg2, bus.imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pc_in = '0; bus.ir_in = '0; bus.valid_in = 1'b0;
        bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.ex_we = 1'b0; bus.ex_is_load = 1'b0; bus.ex_rd = '0;
        bus.mem_we = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    endtask

    task automatic ex_idle();
        bus.ex_we = 1'b0; bus.ex_is_load = 1'b0; bus.ex_rd = '0;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [XLEN-1:0] d);
        bus.wb_we = 1'b1; bus.wb_addr = a; bus.wb_data = d;
        tick();
        bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    endtask

    task automatic load_ifid(input logic [15:0] pc, input logic [15:0] ir);
        bus.pc_in = pc; bus.ir_in = ir; bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0; bus.ir_in = '0;
    endtask

    task automatic test_reset();
        logic [98:0] got;
        idle();
        load_ifid(16'h0020, enc(4'h0, 3'd2, 3'd1, 3'd4, OP_R));
        bus.ex_is_load = 1'b1; bus.ex_we = 1'b1; bus.ex_rd = 3'd2;
        #1;
        n_vec++;
        if ({bus.stall, bus.id_valid} !== 2'b10) begin
            n_err++; $display("FAIL rst_pre_stall: got %b expected 10", {bus.stall, bus.id_valid});
        end
        tick();
        ex_idle();
        #1;
        n_vec++;
        if (bus.stall !== 1'b1) begin
            n_err++; $display("FAIL rst_cnt_stall: got %b expected 1", bus.stall);
        end
        rst_n = 1'b0;
        #1;
        got = all_out();
        n_vec++;
        if (got !== '0) begin
            n_err++; $display("FAIL rst_outputs: got %h expected 0", got);
        end
        #1 rst_n = 1'b1;
        bus.pc_in = 16'h0040; bus.ir_in = enc(4'h1, 3'd0, 3'd0, 3'd1, OP_R); bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        n_vec++;
        if ({bus.id_valid, bus.id_pc, bus.stall} !== {1'b1, 16'h0040, 1'b0}) begin
            n_err++; $display("FAIL rst_first_instr: got %b/%h/%b expected 1/0040/0",
                              bus.id_valid, bus.id_pc, bus.stall);
        end
        tick();
    endtask

    task automatic test_bypass();
        idle();
        load_ifid(16'h0050, enc(4'h0, 3'd0, 3'd3, 3'd1, OP_R));
        bus.wb_we = 1'b1; bus.wb_addr = 3'd3; bus.wb_data = 16'h00AB;
        #1;
        n_vec++;
        if (bus.arg1 !== 16'h00AB) begin
            n_err++; $display("FAIL bypass_same_cycle: got %h expected 00ab", bus.arg1);
        end
        tick();
        bus.wb_addr = 3'd0; bus.wb_data = 16'h0055;
        #1;
        n_vec++;
        if (bus.arg1 !== 16'h0000) begin
            n_err++; $display("FAIL bypass_r0: got %h expected 0000", bus.arg1);
        end
        tick();
        bus.wb_we = 1'b0;
        load_ifid(16'h0052, enc(4'h0, 3'd3, 3'd3, 3'd1, OP_R));
        n_vec++;
        if ({bus.arg1, bus.arg2} !== {16'h00AB, 16'h00AB}) begin
            n_err++; $display("FAIL rf_readback: got %h/%h expected 00ab/00ab", bus.arg1, bus.arg2);
        end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        load_ifid(16'h0060, enc(4'h0, 3'd2, 3'd0, 3'd4, OP_R));
        bus.ex_is_load = 1'b1; bus.ex_we = 1'b1; bus.ex_rd = 3'd2;
        #1;
        n_vec++;
        if ({bus.stall, bus.id_valid, bus.id_pc} !== {1'b1, 1'b0, 16'h0060}) begin
            n_err++; $display("FAIL lu_cycle1: got %b/%b/%h expected 1/0/0060", bus.stall, bus.id_valid, bus.id_pc);
        end
        tick();
        ex_idle();
        #1;
        n_vec++;
        if ({bus.stall, bus.id_valid, bus.id_pc} !== {1'b1, 1'b0, 16'h0060}) begin
            n_err++; $display("FAIL lu_cycle2: got %b/%b/%h expected 1/0/0060", bus.stall, bus.id_valid, bus.id_pc);
        end
        tick();
        n_vec++;
        if ({bus.stall, bus.id_valid, bus.id_pc} !== {1'b0, 1'b1, 16'h0060}) begin
            n_err++; $display("FAIL lu_issue: got %b/%b/%h expected 0/1/0060", bus.stall, bus.id_valid, bus.id_pc);
        end
        tick();
    endtask

    task automatic test_branch_fwd();
        idle();
        wr_reg(3'd1, 16'd5);
        wr_reg(3'd2, 16'd9);
        load_ifid(16'h0010, enc(4'h0, 3'd2, 3'd1, 3'd3, OP_BEQ));
        bus.mem_we = 1'b1; bus.mem_rd = 3'd2; bus.mem_data = 16'd5;
        bus.wb_we = 1'b1; bus.wb_addr = 3'd2; bus.wb_data = 16'd7;
        #1;
        n_vec++;
        if ({bus.redirect, bus.redirect_pc, bus.stall, bus.imm} !== {1'b1, 16'h0016, 1'b0, 16'd6}) begin
            n_err++; $display("FAIL beq_fwd: got %b/%h/%b/%h expected 1/0016/0/0006",
                              bus.redirect, bus.redirect_pc, bus.stall, bus.imm);
        end
        n_vec++;
        if (bus.arg2 !== 16'd7) begin
            n_err++; $display("FAIL beq_arg2_unforwarded: got %h expected 0007", bus.arg2);
        end
        bus.pc_in = 16'h0012; bus.ir_in = enc(4'h1, 3'd1, 3'd1, 3'd1, OP_R); bus.valid_in = 1'b1;
        tick();
        idle();
        #1;
        n_vec++;
        if ({bus.id_valid, bus.opcode, bus.rs1} !== 7'd0) begin
            n_err++; $display("FAIL beq_squash: got %b/%h/%h expected 0/0/0", bus.id_valid, bus.opcode, bus.rs1);
        end
        tick();
    endtask

    task automatic test_branch_dep();
        idle();
        load_ifid(16'h0100, enc(4'hF, 3'd2, 3'd1, 3'd6, OP_BNE));
        bus.ex_we = 1'b1; bus.ex_rd = 3'd1;
        #1;
        n_vec++;
        if ({bus.stall, bus.redirect, bus.id_valid} !== 3'b100) begin
            n_err++; $display("FAIL bne_dep_stall: got %b expected 100", {bus.stall, bus.redirect, bus.id_valid});
        end
        tick();
        ex_idle();
        bus.mem_we = 1'b1; bus.mem_rd = 3'd1; bus.mem_data = 16'd3;
        #1;
        n_vec++;
        if ({bus.stall, bus.redirect, bus.redirect_pc} !== {1'b0, 1'b1, 16'h00FC}) begin
            n_err++; $display("FAIL bne_resolve: got %b/%b/%h expected 0/1/00fc",
                              bus.stall, bus.redirect, bus.redirect_pc);
        end
        tick();
        idle();
    endtask

    task automatic test_jr_blt();
        logic [2:0] pat;
        idle();
        wr_reg(3'd5, 16'hFFFE);
        load_ifid(16'h0200, enc(4'h0, 3'd4, 3'd0, 3'd5, OP_JR));
        bus.ex_is_load = 1'b1; bus.ex_we = 1'b1; bus.ex_rd = 3'd5;
        for (int k = 0; k < 3; k++) begin
            #1 pat[k] = bus.stall;
            tick();
            ex_idle();
        end
        n_vec++;
        if (pat !== 3'b111) begin
            n_err++; $display("FAIL jr_load_dep_stall: got %b expected 111", pat);
        end
        #1;
        n_vec++;
        if ({bus.stall, bus.redirect, bus.redirect_pc, bus.imm} !== {1'b0, 1'b1, 16'h0002, 16'd4}) begin
            n_err++; $display("FAIL jr_wrap: got %b/%b/%h/%h expected 0/1/0002/0004",
                              bus.stall, bus.redirect, bus.redirect_pc, bus.imm);
        end
        tick();
        wr_reg(3'd6, 16'hFFFF);
        wr_reg(3'd7, 16'd1);
        load_ifid(16'h0030, enc(4'h0, 3'd7, 3'd6, 3'd1, OP_BLT));
        n_vec++;
        if ({bus.redirect, bus.redirect_pc} !== {1'b1, 16'h0032}) begin
            n_err++; $display("FAIL blt_taken: got %b/%h expected 1/0032", bus.redirect, bus.redirect_pc);
        end
        tick();
        load_ifid(16'h0040, enc(4'h0, 3'd6, 3'd7, 3'd1, OP_BLT));
        n_vec++;
        if (bus.redirect !== 1'b0) begin
            n_err++; $display("FAIL blt_not_taken: got %b expected 0", bus.redirect);
        end
        tick();
    endtask

    // Behavioural model state
    logic [XLEN-1:0] m_regs [8];
    logic [15:0]     m_pc, m_ir;
    logic            m_valid;
    int              m_busy;

    function automatic logic [XLEN-1:0] m_read(input logic [2:0] a);
        if (a == 3'd0) return '0;
        if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
        return m_regs[a];
    endfunction

    function automatic logic [XLEN-1:0] m_fwd(input logic [2:0] a);
        if (a != 3'd0 && bus.mem_we && bus.mem_rd == a) return bus.mem_data;
        return m_read(a);
    endfunction

    function automatic int as_signed(input logic [XLEN-1:0] v);
        int r = int'(v);
        if (v[XLEN-1]) r = r - (1 << XLEN);
        return r;
    endfunction

    function automatic logic [XLEN-1:0] rnd_data();
        if ($urandom_range(0, 3) == 0) return XLEN'($urandom);
        return XLEN'($urandom_range(0, 3)) - XLEN'(1);
    endfunction

    task automatic test_random();
        logic [2:0]  op, f_rs1, f_rs2, f_rd;
        logic [2:0]  srcs [$];
        int          immv, need, tgt;
        bit          is_ctl, hit, stall_e, idv_e, redir_e, taken;
        logic [15:0] rpc_e;
        logic [98:0] exp_v, got_v;
        idle();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        for (int r = 0; r < 8; r++) m_regs[r] = '0;
        m_pc = '0; m_ir = '0; m_valid = 1'b0; m_busy = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.pc_in      = 16'($urandom);
            bus.ir_in      = 16'($urandom);
            bus.valid_in   = ($urandom_range(0, 3) != 0);
            bus.wb_we      = 1'($urandom_range(0, 1));
            bus.wb_addr    = 3'($urandom_range(0, 7));
            bus.wb_data    = rnd_data();
            bus.ex_is_load = ($urandom_range(0, 3) == 0);
            bus.ex_we      = bus.ex_is_load || ($urandom_range(0, 1) == 1);
            bus.ex_rd      = 3'($urandom_range(0, 7));
            bus.mem_we     = 1'($urandom_range(0, 1));
            bus.mem_rd     = 3'($urandom_range(0, 7));
            bus.mem_data   = rnd_data();
            #1;
            op = m_ir[2:0]; f_rd = m_ir[5:3]; f_rs1 = m_ir[8:6]; f_rs2 = m_ir[11:9];
            is_ctl = (op >= 3'd4);
            if (op == 3'd0) immv = 0;
            else if (op >= 3'd4 && op <= 3'd6) immv = 2 * as_signed(XLEN'($signed({m_ir[15:12], m_ir[5:3]})));
            else immv = as_signed(XLEN'($signed(m_ir[15:9])));
            srcs.delete();
            if (op == OP_JR) srcs.push_back(f_rd);
            else begin srcs.push_back(f_rs1); srcs.push_back(f_rs2); end
            hit = 1'b0;
            foreach (srcs[s]) if (srcs[s] != 3'd0 && srcs[s] == bus.ex_rd) hit = 1'b1;
            need = 0;
            if (m_valid && hit) begin
                if (is_ctl && bus.ex_we) need = bus.ex_is_load ? LL + 1 : 1;
                else if (!is_ctl && bus.ex_is_load) need = LL;
            end
            stall_e = (m_busy > 0) || (need > 0);
            idv_e   = m_valid && !stall_e;
            case (op)
                OP_BEQ:  taken = (m_fwd(f_rs1) == m_fwd(f_rs2));
                OP_BNE:  taken = (m_fwd(f_rs1) != m_fwd(f_rs2));
                OP_BLT:  taken = (as_signed(m_fwd(f_rs1)) < as_signed(m_fwd(f_rs2)));
                default: taken = 1'b0;
            endcase
            redir_e = idv_e && (taken || op == OP_JR);
            tgt = (op == OP_JR) ? int'(m_fwd(f_rd)) + immv : int'(m_pc) + immv;
            rpc_e = redir_e ? 16'(tgt) : 16'd0;
            exp_v = {stall_e, redir_e, rpc_e, idv_e, m_pc, op, m_ir[15:12], f_rs1, f_rs2, f_rd,
                     m_read(f_rs1), m_read(f_rs2), XLEN'(immv)};
            got_v = all_out();
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++; $display("FAIL random cycle %0d: got %h expected %h", cyc, got_v, exp_v);
            end
            // Advance the model by one clock edge
            if (m_busy > 0) m_busy--;
            else if (need > 0) m_busy = need - 1;
            if (!stall_e) begin
                m_pc    = bus.pc_in;
                m_ir    = redir_e ? 16'd0 : bus.ir_in;
                m_valid = redir_e ? 1'b0 : bus.valid_in;
            end
            if (bus.wb_we && bus.wb_addr != 3'd0) m_regs[bus.wb_addr] = bus.wb_data;
            tick();
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        test_reset();
        test_bypass();
        test_load_use();
        test_branch_fwd();
        test_branch_dep();
        test_jr_blt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
